alu_result_router: RTL and testbench

- Consumer end of the ALU datapath in the multi-cycle RV32I core. It captures the ALU result in each control-unit phase: PC+4 at FETCH, PC+imm at DECODE, the operation result at EXECUTE.
- It runs the load/store memory handshake and commits the register-file write and PC update at WRITEBACK.
- Sits between the ALU output and the register file, PC register and data-memory port.

---
 rtl/alu_result_router.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_result_router.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_router.sv
// ALU result router for the multi-cycle RV32I core: phase captures, load/store handshake, writeback/PC commit.
// Optional misaligned-access/target trap output enabled by defining RV32I_MISALIGN_TRAP_EN.
`timescale 1ns/1ps

package rv32i_pkg;
   typedef enum logic [2:0] {
      FETCH_S1     = 3'd0,
      DECODE_S2    = 3'd1,
      EXECUTE_S3   = 3'd2,
      MEMORY_S4    = 3'd3,
      WRITEBACK_S5 = 3'd4
   } RV32I_CONTROL_UNIT_FSM_t;

   typedef enum logic [6:0] {
      R_TYPE      = 7'b0110011,
      I_TYPE      = 7'b0010011,
      I_LOAD_TYPE = 7'b0000011,
      I_JALR_TYPE = 7'b1100111,
      S_TYPE      = 7'b0100011,
      B_TYPE      = 7'b1100011,
      U_LUI_TYPE  = 7'b0110111,
      U_AUI_TYPE  = 7'b0010111,
      J_TYPE      = 7'b1101111
   } RV32I_OPCODE_t;
endpackage

module alu_result_router
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  RV32I_CONTROL_UNIT_FSM_t control_unit_state,
   input  RV32I_OPCODE_t           opcode,
   input  logic [2:0]              funct3,
   input  logic [XLEN-1:0]         alu_result,
   input  logic                    branch_taken,
   input  logic [XLEN-1:0]         rs2,
   input  logic [XLEN-1:0]         mem_rdata,
   input  logic                    mem_ready,
   output logic [XLEN-1:0]         mem_addr,
   output logic [XLEN-1:0]         mem_wdata,
   output logic [3:0]              mem_be,
   output logic                    mem_re,
   output logic                    mem_we,
   output logic                    stall,
   output logic [XLEN-1:0]         rd_wdata,
   output logic                    rd_we,
   output logic [XLEN-1:0]         pc_next,
   output logic                    pc_we
`ifdef RV32I_MISALIGN_TRAP_EN
   ,
   output logic                    misalign
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_WAIT = 2'd2
   } mem_state_t;

   mem_state_t              mem_state;
   mem_state_t              mem_state_nxt;
   RV32I_CONTROL_UNIT_FSM_t prev_state;

   logic [XLEN-1:0] pc_plus4_q;
   logic [XLEN-1:0] target_q;
   logic [XLEN-1:0] exec_q;
   logic [XLEN-1:0] load_q;
   logic            taken_q;
   logic            is_load_q;

   logic            mem_entry;
   logic            wb_entry;
   logic            is_mem_op;
   logic            mis_cond;

   logic            wb_rd_we;
   logic [XLEN-1:0] wb_rd_data;
   logic [XLEN-1:0] wb_pc;

   // Byte enables for a store at byte offset off within the word.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   store_be = 4'b0001 << off;
         2'b01:   store_be = 4'b0011 << off;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
      case (f3[1:0])
         2'b00:   store_data = {4{d[7:0]}};
         2'b01:   store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   // Lane-select the addressed byte/half and extend it to a full register.
   function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] word,
                                                   input logic [1:0] off);
      logic [XLEN-1:0]   shifted;
      logic signed [7:0]  sbyte;
      logic signed [15:0] shalf;
      shifted = word >> {off, 3'b000};
      sbyte   = shifted[7:0];
      shalf   = shifted[15:0];
      case (f3)
         3'b000:  load_extend = XLEN'(sbyte);
         3'b001:  load_extend = XLEN'(shalf);
         3'b100:  load_extend = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_extend = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_extend = shifted;
      endcase
   endfunction

   assign mem_entry = (control_unit_state == MEMORY_S4)    && (prev_state != MEMORY_S4);
   assign wb_entry  = (control_unit_state == WRITEBACK_S5) && (prev_state != WRITEBACK_S5);
   assign is_mem_op = (opcode == I_LOAD_TYPE) || (opcode == S_TYPE);

   // Phase captures: each value is usable from the cycle after its phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_state <= FETCH_S1;
         pc_plus4_q <= '0;
         target_q   <= '0;
         exec_q     <= '0;
         load_q     <= '0;
         taken_q    <= 1'b0;
         is_load_q  <= 1'b0;
      end else begin
         prev_state <= control_unit_state;
         case (control_unit_state)
            FETCH_S1:   pc_plus4_q <= alu_result;
            DECODE_S2:  target_q   <= alu_result;
            EXECUTE_S3: begin
               exec_q  <= alu_result;
               taken_q <= branch_taken;
            end
            default: ;
         endcase
         if (mem_entry)
            is_load_q <= (opcode == I_LOAD_TYPE);
         if ((mem_state == MEM_WAIT) && mem_ready && is_load_q)
            load_q <= mem_rdata;
      end
   end

   // Memory handshake FSM
   always_ff @(posedge clk) begin
      if (rst)
         mem_state <= IDLE;
      else
         mem_state <= mem_state_nxt;
   end

   always_comb begin
      mem_state_nxt = mem_state;
      case (mem_state)
         IDLE:     if (mem_entry && is_mem_op && !mis_cond) mem_state_nxt = MEM_REQ;
         MEM_REQ:  mem_state_nxt = MEM_WAIT;
         MEM_WAIT: if (mem_ready) mem_state_nxt = IDLE;
         default:  mem_state_nxt = IDLE;
      endcase
   end

   // A ready strobe during MEM_REQ is deliberately not looked at.
   always_comb begin
      mem_re    = (mem_state == MEM_REQ) &&  is_load_q;
      mem_we    = (mem_state == MEM_REQ) && !is_load_q;
      stall     = (mem_state == MEM_REQ) || ((mem_state == MEM_WAIT) && !mem_ready);
      mem_addr  = {exec_q[XLEN-1:2], 2'b00};
      mem_be    = 4'b0000;
      mem_wdata = '0;
      if ((mem_state != IDLE) && !is_load_q) begin
         mem_be    = store_be(funct3, exec_q[1:0]);
         mem_wdata = store_data(funct3, rs2);
      end
   end

   // Writeback/PC selection
   always_comb begin
      wb_rd_we   = 1'b0;
      wb_rd_data = exec_q;
      wb_pc      = pc_plus4_q;
      case (opcode)
         R_TYPE, I_TYPE, U_LUI_TYPE, U_AUI_TYPE: begin
            wb_rd_we   = 1'b1;
            wb_rd_data = exec_q;
         end
         J_TYPE: begin
            wb_rd_we   = 1'b1;
            wb_rd_data = pc_plus4_q;
            wb_pc      = exec_q;
         end
         I_JALR_TYPE: begin
            wb_rd_we   = 1'b1;
            wb_rd_data = pc_plus4_q;
            wb_pc      = {exec_q[XLEN-1:1], 1'b0};
         end
         I_LOAD_TYPE: begin
            wb_rd_we   = 1'b1;
            wb_rd_data = load_extend(funct3, load_q, exec_q[1:0]);
         end
         B_TYPE:  wb_pc = taken_q ? target_q : pc_plus4_q;
         default: ;
      endcase
      if (mis_cond) begin
         wb_rd_we = 1'b0;
         wb_pc    = pc_plus4_q;
      end
   end

   // Registered single-cycle commit on entry to WRITEBACK_S5
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_we    <= 1'b0;
         pc_we    <= 1'b0;
         rd_wdata <= '0;
         pc_next  <= '0;
      end else begin
         rd_we <= 1'b0;
         pc_we <= 1'b0;
         if (wb_entry) begin
            rd_we    <= wb_rd_we;
            pc_we    <= 1'b1;
            rd_wdata <= wb_rd_data;
            pc_next  <= wb_pc;
         end
      end
   end

`ifdef RV32I_MISALIGN_TRAP_EN
   logic misalign_q;

   always_comb begin
      mis_cond = 1'b0;
      case (opcode)
         I_LOAD_TYPE, S_TYPE: begin
            case (funct3[1:0])
               2'b01:   mis_cond = exec_q[0];
               2'b10:   mis_cond = (exec_q[1:0] != 2'b00);
               default: mis_cond = 1'b0;
            endcase
         end
         J_TYPE, I_JALR_TYPE: mis_cond = exec_q[1];
         B_TYPE:              mis_cond = taken_q && target_q[1];
         default:             mis_cond = 1'b0;
      endcase
   end

   // Sticky until the next instruction fetch.
   always_ff @(posedge clk) begin
      if (rst)
         misalign_q <= 1'b0;
      else if (control_unit_state == FETCH_S1)
         misalign_q <= 1'b0;
      else if (((control_unit_state == MEMORY_S4) || (control_unit_state == WRITEBACK_S5)) && mis_cond)
         misalign_q <= 1'b1;
   end

   assign misalign = misalign_q;
`else
   assign mis_cond = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_router.sv
// Self-checking bench for alu_result_router: vector table through all phases, scoreboarded memory/writeback events.
`timescale 1ns/1ps

module tb_alu_result_router;
   import rv32i_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   RV32I_CONTROL_UNIT_FSM_t control_unit_state;
   RV32I_OPCODE_t           opcode;
   logic [2:0]              funct3;
   logic [31:0]             alu_result;
   logic                    branch_taken;
   logic [31:0]             rs2;
   logic [31:0]             mem_rdata;
   logic                    mem_ready;
   logic [31:0]             mem_addr;
   logic [31:0]             mem_wdata;
   logic [3:0]              mem_be;
   logic                    mem_re;
   logic                    mem_we;
   logic                    stall;
   logic [31:0]             rd_wdata;
   logic                    rd_we;
   logic [31:0]             pc_next;
   logic                    pc_we;

   always #5 clk = ~clk;

   alu_result_router #(.XLEN(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .control_unit_state (control_unit_state),
      .opcode             (opcode),
      .funct3             (funct3),
      .alu_result         (alu_result),
      .branch_taken       (branch_taken),
      .rs2                (rs2),
      .mem_rdata          (mem_rdata),
      .mem_ready          (mem_ready),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_be             (mem_be),
      .mem_re             (mem_re),
      .mem_we             (mem_we),
      .stall              (stall),
      .rd_wdata           (rd_wdata),
      .rd_we              (rd_we),
      .pc_next            (pc_next),
      .pc_we              (pc_we)
   );

   typedef struct {
      string         name;
      RV32I_OPCODE_t op;
      logic [2:0]    f3;
      logic [31:0]   pc;
      logic [31:0]   imm;
      logic [31:0]   exec;
      logic          taken;
      logic [31:0]   rs2;
      logic [31:0]   rdata;
      int            w;
      logic          exp_rd_we;
      logic [31:0]   exp_rd;
      logic [31:0]   exp_pc;
      logic [31:0]   exp_addr;
      logic [3:0]    exp_be;
      logic [31:0]   exp_wdata;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic        rd_we;
      logic [31:0] rd;
      logic [31:0] pc;
   } wb_exp_t;

   mem_exp_t memq[$];
   wb_exp_t  wbq[$];
   vec_t     vecs[$];
   int       n_checks = 0;
   int       n_fail   = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(string name, RV32I_OPCODE_t op, logic [2:0] f3,
                               logic [31:0] pc, logic [31:0] imm, logic [31:0] exec, logic taken,
                               logic [31:0] r2, logic [31:0] rdata, int w,
                               logic erw, logic [31:0] erd, logic [31:0] epc,
                               logic [31:0] eaddr, logic [3:0] ebe, logic [31:0] ewd);
      vec_t v;
      v.name = name;   v.op = op;       v.f3 = f3;
      v.pc = pc;       v.imm = imm;     v.exec = exec;   v.taken = taken;
      v.rs2 = r2;      v.rdata = rdata; v.w = w;
      v.exp_rd_we = erw; v.exp_rd = erd; v.exp_pc = epc;
      v.exp_addr = eaddr; v.exp_be = ebe; v.exp_wdata = ewd;
      return v;
   endfunction

   // Scoreboard side: every memory or writeback pulse must match the oldest expectation.
   function automatic void monitor();
      mem_exp_t m;
      wb_exp_t  b;
      if (mem_re || mem_we) begin
         if (memq.size() == 0) begin
            chk("mem_req_unexpected", 32'(mem_re | mem_we), 32'd0);
         end else begin
            m = memq.pop_front();
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_re", 32'(mem_re), 32'(!m.we));
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) begin
               chk("mem_be", 32'(mem_be), 32'(m.be));
               chk("mem_wdata", mem_wdata, m.wdata);
            end
         end
      end
      if (rd_we || pc_we) begin
         if (wbq.size() == 0) begin
            chk("wb_unexpected", 32'(rd_we | pc_we), 32'd0);
         end else begin
            b = wbq.pop_front();
            chk("pc_we", 32'(pc_we), 32'd1);
            chk("rd_we", 32'(rd_we), 32'(b.rd_we));
            if (b.rd_we) chk("rd_wdata", rd_wdata, b.rd);
            chk("pc_next", pc_next, b.pc);
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic check_all_zero(string pfx);
      chk({pfx, " stall"},     32'(stall),  32'd0);
      chk({pfx, " mem_re"},    32'(mem_re), 32'd0);
      chk({pfx, " mem_we"},    32'(mem_we), 32'd0);
      chk({pfx, " mem_addr"},  mem_addr,    32'd0);
      chk({pfx, " mem_be"},    32'(mem_be), 32'd0);
      chk({pfx, " mem_wdata"}, mem_wdata,   32'd0);
      chk({pfx, " rd_we"},     32'(rd_we),  32'd0);
      chk({pfx, " pc_we"},     32'(pc_we),  32'd0);
      chk({pfx, " rd_wdata"},  rd_wdata,    32'd0);
      chk({pfx, " pc_next"},   pc_next,     32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      mem_exp_t m;
      wb_exp_t  b;
      logic     is_mem;
      logic     done;
      int       stall_cnt;
      is_mem = (v.op == I_LOAD_TYPE) || (v.op == S_TYPE);
      if (is_mem) begin
         m.we = (v.op == S_TYPE); m.addr = v.exp_addr; m.be = v.exp_be; m.wdata = v.exp_wdata;
         memq.push_back(m);
      end
      b.rd_we = v.exp_rd_we; b.rd = v.exp_rd; b.pc = v.exp_pc;
      wbq.push_back(b);

      opcode = v.op; funct3 = v.f3; rs2 = v.rs2; branch_taken = 1'b0;
      control_unit_state = FETCH_S1;   alu_result = v.pc + 32'd4;  step();
      control_unit_state = DECODE_S2;  alu_result = v.pc + v.imm;  step();
      control_unit_state = EXECUTE_S3; alu_result = v.exec; branch_taken = v.taken; step();
      control_unit_state = MEMORY_S4;  alu_result = 32'h5A5A_0000; step();

      stall_cnt = 0;
      done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         mem_ready = is_mem && (c == v.w + 1);
         mem_rdata = mem_ready ? v.rdata : ~v.rdata;
         #1;
         if (!stall) begin
            done = 1'b1;
            break;
         end
         stall_cnt++;
         step();
      end
      chk({v.name, " stall_released"}, 32'(done), 32'd1);
      chk({v.name, " stall_cycles"}, stall_cnt, is_mem ? v.w + 1 : 0);
      step();
      mem_ready = 1'b0;
      chk({v.name, " mem_events_left"}, memq.size(), 32'd0);

      control_unit_state = WRITEBACK_S5;
      step();
      chk({v.name, " wb_events_left"}, wbq.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      mem_exp_t m;
      rst = 1'b1;
      control_unit_state = FETCH_S1;
      opcode = R_TYPE; funct3 = 3'b000; alu_result = 32'h1234_5678;
      branch_taken = 1'b0; rs2 = 32'hFFFF_FFFF; mem_rdata = 32'h0; mem_ready = 1'b0;

      vecs.push_back(mk("add",       R_TYPE,      3'b000, 32'h100, 32'h0,  32'h7,        1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h7, 32'h104, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("beq_taken", B_TYPE,      3'b000, 32'h200, 32'h40, 32'h0,        1'b1, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h240, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("beq_not",   B_TYPE,      3'b000, 32'h200, 32'h40, 32'h0,        1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h204, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("lb",        I_LOAD_TYPE, 3'b000, 32'h300, 32'h0,  32'h1003,     1'b0, 32'h0, 32'h80AA_BBCC, 3, 1'b1, 32'hFFFF_FF80, 32'h304, 32'h1000, 4'h0, 32'h0));
      vecs.push_back(mk("sh",        S_TYPE,      3'b001, 32'h400, 32'h0,  32'h2002,     1'b0, 32'h1234_ABCD, 32'h0, 1, 1'b0, 32'h0, 32'h404, 32'h2000, 4'b1100, 32'hABCD_ABCD));
      vecs.push_back(mk("jalr",      I_JALR_TYPE, 3'b000, 32'h50,  32'h0,  32'h3001,     1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h54, 32'h3000, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("jal",       J_TYPE,      3'b000, 32'h600, 32'h400, 32'hA00,     1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h604, 32'hA00, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("lw",        I_LOAD_TYPE, 3'b010, 32'h700, 32'h0,  32'h4000,     1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF, 32'h704, 32'h4000, 4'h0, 32'h0));
      vecs.push_back(mk("lhu",       I_LOAD_TYPE, 3'b101, 32'h710, 32'h0,  32'h1002,     1'b0, 32'h0, 32'h80AA_BBCC, 2, 1'b1, 32'h0000_80AA, 32'h714, 32'h1000, 4'h0, 32'h0));
      vecs.push_back(mk("lh",        I_LOAD_TYPE, 3'b001, 32'h720, 32'h0,  32'h1000,     1'b0, 32'h0, 32'h1234_F00D, 0, 1'b1, 32'hFFFF_F00D, 32'h724, 32'h1000, 4'h0, 32'h0));
      vecs.push_back(mk("lbu",       I_LOAD_TYPE, 3'b100, 32'h730, 32'h0,  32'h1001,     1'b0, 32'h0, 32'h80AA_BBCC, 1, 1'b1, 32'h0000_00BB, 32'h734, 32'h1000, 4'h0, 32'h0));
      vecs.push_back(mk("sb",        S_TYPE,      3'b000, 32'h740, 32'h0,  32'h3003,     1'b0, 32'h0000_00A5, 32'h0, 1, 1'b0, 32'h0, 32'h744, 32'h3000, 4'b1000, 32'hA5A5_A5A5));
      vecs.push_back(mk("sw",        S_TYPE,      3'b010, 32'h750, 32'h0,  32'h5004,     1'b0, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 32'h0, 32'h754, 32'h5004, 4'b1111, 32'hCAFE_F00D));
      vecs.push_back(mk("lui",       U_LUI_TYPE,  3'b000, 32'h760, 32'h0,  32'h1234_5000, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h1234_5000, 32'h764, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("auipc",     U_AUI_TYPE,  3'b000, 32'h770, 32'h0,  32'h1770,     1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h1770, 32'h774, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("unknown",   RV32I_OPCODE_t'(7'h7F), 3'b000, 32'h800, 32'h0, 32'h55, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h804, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("addi_wrap", I_TYPE,      3'b000, 32'h810, 32'h0,  32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 32'h814, 32'h0, 4'h0, 32'h0));
      vecs.push_back(mk("b_wrap",    B_TYPE,      3'b001, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1'b0, 32'h0, 32'h10, 32'h0, 4'h0, 32'h0));

      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while the load is waiting on memory aborts it cleanly.
      m.we = 1'b0; m.addr = 32'h6000; m.be = 4'h0; m.wdata = 32'h0;
      memq.push_back(m);
      opcode = I_LOAD_TYPE; funct3 = 3'b010;
      control_unit_state = FETCH_S1;   alu_result = 32'h904;  step();
      control_unit_state = DECODE_S2;  alu_result = 32'h900;  step();
      control_unit_state = EXECUTE_S3; alu_result = 32'h6000; step();
      control_unit_state = MEMORY_S4;  mem_ready = 1'b0;      step();
      chk("abort req_seen", memq.size(), 32'd0);
      step();
      chk("abort stall_in_wait", 32'(stall), 32'd1);
      rst = 1'b1;
      control_unit_state = FETCH_S1;
      step();
      check_all_zero("abort");
      rst = 1'b0;

      run_vec(vecs[0]);

      control_unit_state = FETCH_S1;
      step();
      step();
      chk("final mem_queue_empty", memq.size(), 32'd0);
      chk("final wb_queue_empty", wbq.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
